cpu_sequencer: RTL

Multi-cycle state sequencer for the MIPS CPU core. Generates the 3-bit `state` consumed by the instruction decoder. Issues the instruction-fetch and data-access strobes on the shared Avalon memory port, and stalls on `waitrequest`. Holds EXEC for a fixed multiply/divide latency, generates PC/IR/register-file commit strobes, and owns the `active` / halt status.

---
 rtl/cpu_sequencer_if.sv | 22 ++
 rtl/cpu_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Avalon memory-port signals shared by the sequencer (master) and memory (slave).
// Ports: waitrequest (slave->master), mem_read, mem_write, addr_sel (master->slave).
interface cpu_sequencer_if;
  logic waitrequest;
  logic mem_read;
  logic mem_write;
  logic addr_sel;

  modport master (
    input  waitrequest,
    output mem_read,
    output mem_write,
    output addr_sel
  );

  modport slave (
    output waitrequest,
    input  mem_read,
    input  mem_write,
    input  addr_sel
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for the MIPS core.
// Ports: clk, reset_n, bus (Avalon master), is_load, is_store, multdiv,
// halt_req in; state, ir_en, pc_en, wb_en, active out.
// Optional: SEQ_PERF_CNT_EN adds cycle_count / stall_count outputs.
module cpu_sequencer #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cpu_sequencer_if.master        bus,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic                   multdiv,
  input  logic                   halt_req,
  output logic [2:0]             state,
  output logic                   ir_en,
  output logic                   pc_en,
  output logic                   wb_en,
  output logic                   active
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] MD_LAT = 4'(MD_LATENCY);

  state_e     state_q, state_d;
  logic       active_q, active_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ld_q, ld_d;
  logic       md_hold;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_d          = ld_q;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr_sel  = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    wb_en         = 1'b0;
    md_hold       = 1'b0;
    // Nothing moves until active is set; this also drops the
    // bus request during and right after reset.
    if (active_q) begin
      unique case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          if (!bus.waitrequest) begin
            ir_en   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          cnt_d   = MD_LAT;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (multdiv) begin
            if (cnt_q == 4'd0) begin
              wb_en   = 1'b1;
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end else begin
              md_hold = 1'b1;
              cnt_d   = cnt_q - 4'd1;
            end
          end else if (is_load) begin
            ld_d    = 1'b1;
            state_d = S_MEM;
          end else if (is_store) begin
            ld_d    = 1'b0;
            state_d = S_MEM;
          end else begin
            wb_en   = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          bus.addr_sel  = 1'b1;
          bus.mem_read  = ld_q;
          bus.mem_write = !ld_q;
          if (!bus.waitrequest) begin
            if (ld_q) begin
              state_d = S_WB;
            end else begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_WB: begin
          wb_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
    if (pc_en && halt_req) begin
      state_d = S_HALT;
    end
    active_d = (state_d != S_HALT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
    end
  end

  assign state  = state_q;
  assign active = active_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] stl_q, stl_d;
  logic        bus_stall;

  always_comb begin
    bus_stall = bus.waitrequest &&
                (state_q == S_FETCH || state_q == S_MEM);
    cyc_d = cyc_q;
    stl_d = stl_q;
    if (active_q) begin
      cyc_d = cyc_q + 32'd1;
      if (bus_stall || md_hold) begin
        stl_d = stl_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= 32'd0;
      stl_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
    end
  end

  assign cycle_count = cyc_q;
  assign stall_count = stl_q;
`endif

endmodule
